addressing_config_writer: RTL and testbench
===========================================

ADDRESSING_CONFIG_WRITER -- requirements
Module: addressing_config_writer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36, ALU write data width.
REQ-002 SHALL have parameter D_OPERAND_WIDTH, default 12, ALU write address width.
REQ-003 SHALL have parameter THREAD_COUNT, default 8, number of round-robin threads.
REQ-004 SHALL have parameter THREAD_ADDR_WIDTH, default 3, thread ID width.
REQ-005 SHALL have parameter INITIAL_THREAD, default 6, write-stage thread ID after reset.
REQ-006 SHALL have parameter PO_INC_COUNT, default 4, number of PO/INC entries per thread.
REQ-007 SHALL have parameter PO_INC_COUNT_ADDR_WIDTH, default 2, PO/INC index width.
REQ-008 SHALL have parameters DO_WRITE_ADDR, PO_WRITE_ADDR, INC_WRITE_ADDR, defaults 1024, 1028, 1032, write-address bases per kind.
REQ-009 SHALL have parameters DO_WORD_OFFSET, PO_WORD_OFFSET, INC_WORD_OFFSET, defaults 0, 0, 12, LSB position of each field in the write word.
REQ-010 SHALL have port clock, input, 1, sole clock; reset is synchronous and active-low.
REQ-011 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-012 SHALL have port cfg_valid, input, 1, config record offered.
REQ-013 SHALL have port cfg_ready, output, 1, record accepted when cfg_valid and cfg_ready are both high.
REQ-014 SHALL have port cfg_thread, input, THREAD_ADDR_WIDTH, target thread.
REQ-015 SHALL have port cfg_kind, input, 2, 0=DO, 1=PO, 2=INC, 3=illegal.
REQ-016 SHALL have port cfg_index, input, PO_INC_COUNT_ADDR_WIDTH, PO/INC entry; ignored for DO.
REQ-017 SHALL have port cfg_value, input, WORD_WIDTH, right-aligned field value, pre-masked by sender.
REQ-018 SHALL have port ALU_write_busy_next, input, 1, ALU writes in the next cycle.
REQ-019 SHALL have ports cfg_write_en (1), cfg_write_addr (D_OPERAND_WIDTH), cfg_write_data (WORD_WIDTH), outputs, injected ALU-side write.
REQ-020 SHALL have ports cfg_error (1, sticky illegal record) and busy (1, record pending), outputs.

Function
REQ-021 SHALL keep write_thread counter, incrementing every cycle, wrapping THREAD_COUNT-1 -> 0, reset to INITIAL_THREAD.
REQ-022 SHALL implement states IDLE, WAIT, WRITE; cfg_ready high only in IDLE; busy high in WAIT and WRITE.
REQ-023 SHALL on accept latch record and go IDLE->WAIT; illegal record (kind 3, or PO/INC with index >= PO_INC_COUNT) SHALL instead set cfg_error, stay IDLE, produce no write.
REQ-024 SHALL go WAIT->WRITE when next write_thread equals latched thread and ALU_write_busy_next is low; otherwise stay WAIT (retry next rotation).
REQ-025 SHALL in WRITE assert registered cfg_write_en for exactly one cycle, coinciding with write_thread == latched thread, then return to IDLE.
REQ-026 SHALL drive cfg_write_addr = kind base (+ cfg_index for PO/INC), truncated to D_OPERAND_WIDTH.
REQ-027 SHALL drive cfg_write_data = cfg_value shifted left by kind word offset, truncated to WORD_WIDTH, zero elsewhere.
REQ-028 SHALL hold cfg_write_addr/cfg_write_data at zero whenever cfg_write_en is low.
REQ-029 SHALL give minimum latency of 2 cycles accept-to-write; maximum THREAD_COUNT+1 when never busy.
REQ-030 SHALL, if accept occurs with target one thread ahead, write at cycle accept+2 or later rotation, never same-cycle.

Reset
REQ-031 SHALL on reset_n low: state IDLE, cfg_ready 0 during reset then 1, cfg_write_en 0, addr/data 0, cfg_error 0, busy 0, write_thread INITIAL_THREAD.
REQ-032 SHALL discard any pending record on reset mid-operation with no write issued.

Structure
REQ-033 SHALL place cfg_kind encodings and state encodings in the shared Addressing constants include file.
REQ-034 SHALL instantiate one sub-module, Thread_Number, for the write_thread counter; no other sub-modules.

Verification
REQ-035 SHALL test DO: reset, thread 6 after reset; accept {thread 1, DO, value 0x3F} -> one write addr 1024, data 0x3F, when write_thread 1.
REQ-036 SHALL test INC field: {thread 2, INC, index 3, value 5} -> addr 1035, data 5<<12 = 0x5000.
REQ-037 SHALL test busy: ALU_write_busy_next high at target slot -> no write; write 8 cycles later, busy stays high meanwhile.
REQ-038 SHALL test errors: kind 3, then PO index 4 with PO_INC_COUNT 4 -> cfg_error 1, no cfg_write_en, cfg_ready stays 1.
REQ-039 SHALL test reset mid-WAIT: reset_n low 1 cycle -> no write, cfg_error 0, write_thread 6.
REQ-040 SHALL test back-to-back: records for threads 0..7 sent when ready -> eight writes, each matching its thread, no drops.

Source files
------------

// File: rtl/addressing_config_writer_pkg.sv
// Shared constants for the addressing configuration writer: record kinds
// and controller state encodings.
package addressing_config_writer_pkg;

  typedef enum logic [1:0] {
    KIND_DO      = 2'd0,
    KIND_PO      = 2'd1,
    KIND_INC     = 2'd2,
    KIND_ILLEGAL = 2'd3
  } cfg_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/addressing_config_writer_thread_number.sv
// Round-robin write-stage thread counter. Exposes the thread that will own
// the write slot in the following cycle.
module Thread_Number #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 6
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  output logic [THREAD_ADDR_WIDTH-1:0] o_nextThread
);

  logic [THREAD_ADDR_WIDTH-1:0] r_thread;
  logic [THREAD_ADDR_WIDTH-1:0] w_nextThread;

  always_comb begin
    w_nextThread = (r_thread == THREAD_ADDR_WIDTH'(THREAD_COUNT - 1)) ? '0 : r_thread + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_thread <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
    end else begin
      r_thread <= w_nextThread;
    end
  end

  assign o_nextThread = w_nextThread;

endmodule

// File: rtl/addressing_config_writer.sv
// Accepts one addressing config record at a time and injects it as a single
// ALU-side write in the target thread's write slot, skipping slots the ALU uses.
module addressing_config_writer
  import addressing_config_writer_pkg::*;
#(
  parameter int WORD_WIDTH              = 36,
  parameter int D_OPERAND_WIDTH         = 12,
  parameter int THREAD_COUNT            = 8,
  parameter int THREAD_ADDR_WIDTH       = 3,
  parameter int INITIAL_THREAD          = 6,
  parameter int PO_INC_COUNT            = 4,
  parameter int PO_INC_COUNT_ADDR_WIDTH = 2,
  parameter int DO_WRITE_ADDR           = 1024,
  parameter int PO_WRITE_ADDR           = 1028,
  parameter int INC_WRITE_ADDR          = 1032,
  parameter int DO_WORD_OFFSET          = 0,
  parameter int PO_WORD_OFFSET          = 0,
  parameter int INC_WORD_OFFSET         = 12
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [THREAD_ADDR_WIDTH-1:0]       cfg_thread,
  input  logic [1:0]                         cfg_kind,
  input  logic [PO_INC_COUNT_ADDR_WIDTH-1:0] cfg_index,
  input  logic [WORD_WIDTH-1:0]              cfg_value,
  input  logic                               ALU_write_busy_next,
  output logic                               cfg_write_en,
  output logic [D_OPERAND_WIDTH-1:0]         cfg_write_addr,
  output logic [WORD_WIDTH-1:0]              cfg_write_data,
  output logic                               cfg_error,
  output logic                               busy
);

  state_t                               r_state;
  state_t                               w_stateNext;
  logic [THREAD_ADDR_WIDTH-1:0]         r_thread;
  cfg_kind_t                            r_kind;
  logic [PO_INC_COUNT_ADDR_WIDTH-1:0]   r_index;
  logic [WORD_WIDTH-1:0]                r_value;
  logic                                 r_writeEn;
  logic [D_OPERAND_WIDTH-1:0]           r_writeAddr;
  logic [WORD_WIDTH-1:0]                r_writeData;
  logic                                 r_error;

  logic [THREAD_ADDR_WIDTH-1:0]         w_nextThread;
  logic                                 w_accept;
  logic                                 w_illegal;
  logic                                 w_slotFree;
  logic [D_OPERAND_WIDTH-1:0]           w_addr;
  logic [WORD_WIDTH-1:0]                w_data;

  Thread_Number #(
    .THREAD_COUNT      (THREAD_COUNT),
    .THREAD_ADDR_WIDTH (THREAD_ADDR_WIDTH),
    .INITIAL_THREAD    (INITIAL_THREAD)
  ) u_threadNumber (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .o_nextThread (w_nextThread)
  );

  assign cfg_ready  = reset_n && (r_state == ST_IDLE);
  assign busy       = (r_state == ST_WAIT) || (r_state == ST_WRITE);
  assign w_accept   = cfg_valid && (r_state == ST_IDLE);
  assign w_illegal  = (cfg_kind == KIND_ILLEGAL) ||
                      ((cfg_kind != KIND_DO) && (32'(cfg_index) >= 32'(PO_INC_COUNT)));
  // The slot is taken only when the next cycle belongs to our thread and the ALU leaves it unused
  assign w_slotFree = (w_nextThread == r_thread) && !ALU_write_busy_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_illegal) w_stateNext = ST_WAIT;
      ST_WAIT:  if (w_slotFree) w_stateNext = ST_WRITE;
      ST_WRITE: w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    case (r_kind)
      KIND_DO: begin
        w_addr = D_OPERAND_WIDTH'(DO_WRITE_ADDR);
        w_data = r_value << DO_WORD_OFFSET;
      end
      KIND_PO: begin
        w_addr = D_OPERAND_WIDTH'(PO_WRITE_ADDR) + D_OPERAND_WIDTH'(r_index);
        w_data = r_value << PO_WORD_OFFSET;
      end
      KIND_INC: begin
        w_addr = D_OPERAND_WIDTH'(INC_WRITE_ADDR) + D_OPERAND_WIDTH'(r_index);
        w_data = r_value << INC_WORD_OFFSET;
      end
      default: begin
        w_addr = '0;
        w_data = '0;
      end
    endcase
  end

  // Write outputs are registered and forced to zero outside the single write cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_thread    <= '0;
      r_kind      <= KIND_DO;
      r_index     <= '0;
      r_value     <= '0;
      r_error     <= 1'b0;
      r_writeEn   <= 1'b0;
      r_writeAddr <= '0;
      r_writeData <= '0;
    end else begin
      if (w_accept) begin
        if (w_illegal) begin
          r_error <= 1'b1;
        end else begin
          r_thread <= cfg_thread;
          r_kind   <= cfg_kind_t'(cfg_kind);
          r_index  <= cfg_index;
          r_value  <= cfg_value;
        end
      end
      r_writeEn   <= (w_stateNext == ST_WRITE);
      r_writeAddr <= (w_stateNext == ST_WRITE) ? w_addr : '0;
      r_writeData <= (w_stateNext == ST_WRITE) ? w_data : '0;
    end
  end

  assign cfg_write_en   = r_writeEn;
  assign cfg_write_addr = r_writeAddr;
  assign cfg_write_data = r_writeData;
  assign cfg_error      = r_error;

endmodule

// File: tb/tb_addressing_config_writer.sv
// Randomised and directed checks of the config writer against a slot-timing
// model derived from a free-running thread rotation.
module tb_addressing_config_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_thread;
  logic [1:0]  cfg_kind;
  logic [2:0]  cfg_index;
  logic [35:0] cfg_value;
  logic        ALU_write_busy_next;
  logic        cfg_write_en;
  logic [11:0] cfg_write_addr;
  logic [35:0] cfg_write_data;
  logic        cfg_error;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  int mThread;

  always #5 clock = ~clock;

  addressing_config_writer #(
    .WORD_WIDTH              (36),
    .D_OPERAND_WIDTH         (12),
    .THREAD_COUNT            (8),
    .THREAD_ADDR_WIDTH       (3),
    .INITIAL_THREAD          (6),
    .PO_INC_COUNT            (4),
    .PO_INC_COUNT_ADDR_WIDTH (3),
    .DO_WRITE_ADDR           (1024),
    .PO_WRITE_ADDR           (1028),
    .INC_WRITE_ADDR          (1032),
    .DO_WORD_OFFSET          (0),
    .PO_WORD_OFFSET          (0),
    .INC_WORD_OFFSET         (12)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .cfg_thread          (cfg_thread),
    .cfg_kind            (cfg_kind),
    .cfg_index           (cfg_index),
    .cfg_value           (cfg_value),
    .ALU_write_busy_next (ALU_write_busy_next),
    .cfg_write_en        (cfg_write_en),
    .cfg_write_addr      (cfg_write_addr),
    .cfg_write_data      (cfg_write_data),
    .cfg_error           (cfg_error),
    .busy                (busy)
  );

  // Reference rotation: thread owning the write stage in each cycle
  always @(posedge clock) begin
    if (!reset_n) mThread <= 6;
    else          mThread <= (mThread + 1) % 8;
  end

  // First cycle offset after accept whose slot belongs to the target and was not claimed by the ALU
  function automatic int expOffset(int thrA, int target, int busyCycles);
    for (int n = 2; n < 40; n++) begin
      if (((thrA + n) % 8) == target && (n - 1) > busyCycles) return n;
    end
    return -1;
  endfunction

  function automatic logic [11:0] expAddr(int kind, int idx);
    int a;
    if (kind == 0)      a = 1024;
    else if (kind == 1) a = 1028 + idx;
    else                a = 1032 + idx;
    return 12'(a);
  endfunction

  function automatic logic [35:0] expData(int kind, logic [35:0] val);
    if (kind == 2) return val * 36'd4096;
    return val;
  endfunction

  task automatic send(input int thr, input int kind, input int idx, input logic [35:0] val,
                      output int thrA, output bit ok);
    cfg_thread = 3'(thr);
    cfg_kind   = 2'(kind);
    cfg_index  = 3'(idx);
    cfg_value  = val;
    cfg_valid  = 1'b1;
    ok   = 1'b0;
    thrA = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cfg_ready === 1'b1) begin
        thrA = mThread;
        ok   = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Observes cycles following an accept; drives the ALU busy hint for the first busyCycles of them
  task automatic watch(input int busyCycles, input int maxCycles, output int wOff, output int wCount,
                       output int wThr, output logic [11:0] wAddr, output logic [35:0] wData,
                       output bit zeroBad, output bit busyBad);
    wOff = -1; wCount = 0; wThr = -1; wAddr = '0; wData = '0; zeroBad = 1'b0; busyBad = 1'b0;
    for (int n = 1; n <= maxCycles; n++) begin
      ALU_write_busy_next = (n <= busyCycles);
      @(negedge clock);
      if (cfg_write_en === 1'b1) begin
        wCount++;
        if (wOff < 0) begin
          wOff = n; wThr = mThread; wAddr = cfg_write_addr; wData = cfg_write_data;
        end
      end else begin
        if (cfg_write_addr !== 12'd0 || cfg_write_data !== 36'd0) zeroBad = 1'b1;
        if (wOff < 0 && busy !== 1'b1) busyBad = 1'b1;
      end
      @(posedge clock);
      #1;
      if (wOff >= 0 && n > wOff) break;
    end
    ALU_write_busy_next = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_thread = '0; cfg_kind = '0; cfg_index = '0;
    cfg_value = '0; ALU_write_busy_next = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkCount++; if (cfg_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", cfg_ready); else passCount++;
    checkCount++; if (cfg_write_en !== 1'b0) $display("[TB] FAIL rst_en: got %b want 0", cfg_write_en); else passCount++;
    checkCount++; if (cfg_write_addr !== 12'd0) $display("[TB] FAIL rst_addr: got %0d want 0", cfg_write_addr); else passCount++;
    checkCount++; if (cfg_write_data !== 36'd0) $display("[TB] FAIL rst_data: got %h want 0", cfg_write_data); else passCount++;
    checkCount++; if (cfg_error !== 1'b0) $display("[TB] FAIL rst_error: got %b want 0", cfg_error); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else passCount++;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkCount++; if (cfg_ready !== 1'b1) $display("[TB] FAIL post_rst_ready: got %b want 1", cfg_ready); else passCount++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_record(input string name, input int thr, input int kind, input int idx,
                             input logic [35:0] val);
    int thrA, wOff, wCount, wThr, e;
    bit ok, zeroBad, busyBad;
    logic [11:0] wAddr;
    logic [35:0] wData;
    send(thr, kind, idx, val, thrA, ok);
    watch(0, 20, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
    e = expOffset(thrA, thr, 0);
    checkCount++; if (ok !== 1'b1) $display("[TB] FAIL %s_accept: got %b want 1", name, ok); else passCount++;
    checkCount++; if (wCount !== 1) $display("[TB] FAIL %s_count: got %0d want 1", name, wCount); else passCount++;
    checkCount++; if (wOff !== e) $display("[TB] FAIL %s_latency: got %0d want %0d", name, wOff, e); else passCount++;
    checkCount++; if (wThr !== thr) $display("[TB] FAIL %s_thread: got %0d want %0d", name, wThr, thr); else passCount++;
    checkCount++; if (wAddr !== expAddr(kind, idx)) $display("[TB] FAIL %s_addr: got %0d want %0d", name, wAddr, expAddr(kind, idx)); else passCount++;
    checkCount++; if (wData !== expData(kind, val)) $display("[TB] FAIL %s_data: got %h want %h", name, wData, expData(kind, val)); else passCount++;
    checkCount++; if (zeroBad || busyBad) $display("[TB] FAIL %s_idle: got zero=%b busy=%b want 0 0", name, zeroBad, busyBad); else passCount++;
  endtask

  task automatic test_do();
    test_record("do", 1, 0, 0, 36'h3F);
  endtask

  task automatic test_inc();
    test_record("inc", 2, 2, 3, 36'd5);
  endtask

  task automatic test_busy();
    int thrA, wOff, wCount, wThr, target, d, e;
    bit ok, zeroBad, busyBad;
    logic [11:0] wAddr;
    logic [35:0] wData;
    target = (mThread + 4) % 8;
    send(target, 1, 2, 36'h123456789, thrA, ok);
    d = (target - thrA + 8) % 8;
    if (d < 2) d += 8;
    watch(d - 1, 30, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
    e = expOffset(thrA, target, d - 1);
    checkCount++; if (ok !== 1'b1) $display("[TB] FAIL busy_accept: got %b want 1", ok); else passCount++;
    checkCount++; if (wOff !== e || e !== d + 8) $display("[TB] FAIL busy_latency: got %0d want %0d", wOff, d + 8); else passCount++;
    checkCount++; if (wCount !== 1) $display("[TB] FAIL busy_count: got %0d want 1", wCount); else passCount++;
    checkCount++; if (busyBad) $display("[TB] FAIL busy_held: got %b want 0", busyBad); else passCount++;
    checkCount++; if (wAddr !== 12'd1030) $display("[TB] FAIL busy_addr: got %0d want 1030", wAddr); else passCount++;
  endtask

  task automatic test_back_to_back();
    int thrA, wOff, wCount, wThr, total;
    bit ok, zeroBad, busyBad;
    logic [11:0] wAddr;
    logic [35:0] wData;
    total = 0;
    for (int t = 0; t < 8; t++) begin
      send(t, t % 3, t % 4, 36'(t * 17 + 1), thrA, ok);
      watch(0, 20, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
      total += wCount;
      checkCount++; if (wThr !== t) $display("[TB] FAIL b2b_thread: got %0d want %0d", wThr, t); else passCount++;
      checkCount++; if (wOff !== expOffset(thrA, t, 0)) $display("[TB] FAIL b2b_latency: got %0d want %0d", wOff, expOffset(thrA, t, 0)); else passCount++;
      checkCount++; if (wAddr !== expAddr(t % 3, t % 4)) $display("[TB] FAIL b2b_addr: got %0d want %0d", wAddr, expAddr(t % 3, t % 4)); else passCount++;
      checkCount++; if (wData !== expData(t % 3, 36'(t * 17 + 1))) $display("[TB] FAIL b2b_data: got %h want %h", wData, expData(t % 3, 36'(t * 17 + 1))); else passCount++;
    end
    checkCount++; if (total !== 8) $display("[TB] FAIL b2b_total: got %0d want 8", total); else passCount++;
  endtask

  task automatic test_random();
    int thrA, wOff, wCount, wThr, t, k, idx, bc, e;
    bit ok, zeroBad, busyBad;
    logic [11:0] wAddr;
    logic [35:0] wData, val;
    for (int it = 0; it < 12; it++) begin
      t   = $urandom_range(0, 7);
      k   = $urandom_range(0, 2);
      idx = $urandom_range(0, 3);
      bc  = $urandom_range(0, 9);
      if (k == 2) val = 36'($urandom & 32'h00FF_FFFF);
      else        val = {4'($urandom_range(0, 15)), 32'($urandom)};
      send(t, k, idx, val, thrA, ok);
      watch(bc, 30, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
      e = expOffset(thrA, t, bc);
      checkCount++; if (wCount !== 1) $display("[TB] FAIL rnd_count: got %0d want 1", wCount); else passCount++;
      checkCount++; if (wOff !== e) $display("[TB] FAIL rnd_latency: got %0d want %0d", wOff, e); else passCount++;
      checkCount++; if (wAddr !== expAddr(k, idx)) $display("[TB] FAIL rnd_addr: got %0d want %0d", wAddr, expAddr(k, idx)); else passCount++;
      checkCount++; if (wData !== expData(k, val)) $display("[TB] FAIL rnd_data: got %h want %h", wData, expData(k, val)); else passCount++;
      checkCount++; if (zeroBad || busyBad) $display("[TB] FAIL rnd_idle: got zero=%b busy=%b want 0 0", zeroBad, busyBad); else passCount++;
    end
  endtask

  task automatic test_errors();
    int thrA, wOff, wCount, wThr;
    bit ok, zeroBad, busyBad;
    logic [11:0] wAddr;
    logic [35:0] wData;
    checkCount++; if (cfg_error !== 1'b0) $display("[TB] FAIL err_clean: got %b want 0", cfg_error); else passCount++;
    send(0, 3, 0, 36'd9, thrA, ok);
    watch(0, 12, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
    @(negedge clock);
    checkCount++; if (wCount !== 0) $display("[TB] FAIL err_kind_write: got %0d want 0", wCount); else passCount++;
    checkCount++; if (cfg_error !== 1'b1) $display("[TB] FAIL err_kind_flag: got %b want 1", cfg_error); else passCount++;
    checkCount++; if (cfg_ready !== 1'b1) $display("[TB] FAIL err_kind_ready: got %b want 1", cfg_ready); else passCount++;
    @(posedge clock);
    #1;
    send(0, 1, 4, 36'd7, thrA, ok);
    watch(0, 12, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
    @(negedge clock);
    checkCount++; if (wCount !== 0) $display("[TB] FAIL err_index_write: got %0d want 0", wCount); else passCount++;
    checkCount++; if (cfg_error !== 1'b1) $display("[TB] FAIL err_index_flag: got %b want 1", cfg_error); else passCount++;
    checkCount++; if (cfg_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL err_index_ready: got ready=%b busy=%b want 1 0", cfg_ready, busy); else passCount++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    int thrA, wOff, wCount, wThr;
    bit ok, zeroBad, busyBad;
    logic [11:0] wAddr;
    logic [35:0] wData;
    send((mThread + 1) % 8, 0, 0, 36'hABC, thrA, ok);
    @(negedge clock);
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL rmw_waiting: got %b want 1", busy); else passCount++;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    watch(0, 12, wOff, wCount, wThr, wAddr, wData, zeroBad, busyBad);
    @(negedge clock);
    checkCount++; if (wCount !== 0) $display("[TB] FAIL rmw_write: got %0d want 0", wCount); else passCount++;
    checkCount++; if (cfg_error !== 1'b0) $display("[TB] FAIL rmw_error: got %b want 0", cfg_error); else passCount++;
    checkCount++; if (busy !== 1'b0 || cfg_ready !== 1'b1) $display("[TB] FAIL rmw_idle: got busy=%b ready=%b want 0 1", busy, cfg_ready); else passCount++;
    @(posedge clock);
    #1;
    test_record("rmw_after", 1, 0, 0, 36'h3F);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_do();
    test_inc();
    test_busy();
    test_back_to_back();
    test_random();
    test_errors();
    test_reset_mid_wait();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
